// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the datamemory it fronts.
package dmem_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    FORCE1 = 1'b1
  } arb_state_t;

  localparam int STARVE_W   = 4;
  localparam int DMEM_DEPTH = 51;

endpackage

// File: rtl/dmem_resp_reg.sv
// Registered per-port response: one-cycle valid strobe, error flag and read data.
module dmem_resp_reg #(
  parameter int CSIZE = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           gnt,
  input  logic           we,
  input  logic           in_range,
  input  logic [CSIZE:0] mem_rd,
  output logic           valid,
  output logic           err,
  output logic [CSIZE:0] rdata
);

  // Read data is the pre-write memory value; writes and errors return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      valid <= gnt;
      err   <= gnt & ~in_range;
      rdata <= (gnt & ~we & in_range) ? mem_rd : '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority arbiter sharing datamemory between the MEM stage (port 0) and
// the debug/loader port (port 1), with a starvation guard for port 1.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int CSIZE      = 31,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           p0_req,
  input  logic           p0_we,
  input  logic [CSIZE:0] p0_addr,
  input  logic [CSIZE:0] p0_wdata,
  output logic           p0_gnt,
  output logic           p0_valid,
  output logic [CSIZE:0] p0_rdata,
  output logic           p0_err,
  input  logic           p1_req,
  input  logic           p1_we,
  input  logic [CSIZE:0] p1_addr,
  input  logic [CSIZE:0] p1_wdata,
  output logic           p1_gnt,
  output logic           p1_valid,
  output logic [CSIZE:0] p1_rdata,
  output logic           p1_err,
  output logic [CSIZE:0] mem_a,
  output logic [CSIZE:0] mem_wd,
  output logic           mem_we,
  input  logic [CSIZE:0] mem_rd
);

  localparam logic [CSIZE:0]      DEPTH_A = (CSIZE+1)'(DEPTH);
  localparam logic [STARVE_W-1:0] SMAX    = STARVE_W'(STARVE_MAX);

  arb_state_t          state, state_nxt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                p0_in_range, p1_in_range;

  assign p0_in_range = (p0_addr < DEPTH_A);
  assign p1_in_range = (p1_addr < DEPTH_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nxt;
  end

  // FORCE1 lasts exactly one cycle whether or not port 1 still requests.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (starve_cnt == SMAX) state_nxt = FORCE1;
      FORCE1:  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    case (state)
      ARB: begin
        p0_gnt = p0_req;
        p1_gnt = p1_req & ~p0_req;
      end
      FORCE1:  p1_gnt = p1_req;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     starve_cnt <= '0;
    else if (p1_gnt || !p1_req)     starve_cnt <= '0;
    else if (starve_cnt != SMAX)    starve_cnt <= starve_cnt + 1'b1;
  end

  // Out-of-range writes never reach the memory write enable.
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (p0_gnt) begin
      mem_a  = p0_addr;
      mem_wd = p0_wdata;
      mem_we = p0_we & p0_in_range;
    end else if (p1_gnt) begin
      mem_a  = p1_addr;
      mem_wd = p1_wdata;
      mem_we = p1_we & p1_in_range;
    end
  end

  dmem_resp_reg #(.CSIZE(CSIZE)) u_resp0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .gnt      (p0_gnt),
    .we       (p0_we),
    .in_range (p0_in_range),
    .mem_rd   (mem_rd),
    .valid    (p0_valid),
    .err      (p0_err),
    .rdata    (p0_rdata)
  );

  dmem_resp_reg #(.CSIZE(CSIZE)) u_resp1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .gnt      (p1_gnt),
    .we       (p1_we),
    .in_range (p1_in_range),
    .mem_rd   (mem_rd),
    .valid    (p1_valid),
    .err      (p1_err),
    .rdata    (p1_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural memory and arbitration model.
module tb_dmem_arbiter;

  localparam int CSIZE = 31;
  localparam int DEPTH = 51;
  localparam int SM    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p0_gnt, p0_valid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_valid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.CSIZE(CSIZE), .DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_valid(p0_valid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_valid(p1_valid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  // Behavioural datamemory attached to the DUT.
  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk)
    if (mem_we && mem_a < DEPTH) tb_mem[int'(mem_a)] <= mem_wd;

  always_comb begin
    mem_rd = '0;
    if (mem_a < DEPTH) mem_rd = tb_mem[int'(mem_a)];
  end

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          v;
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  exp_t q0[$], q1[$];
  req_t pd0, pd1;
  int   cyc = 0;
  int   tests = 0, fails = 0;
  bit   forced;
  int   lost;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each response must appear exactly in the cycle it was scheduled for.
  initial forever begin
    @(negedge clk);
    if (q0.size() > 0 && q0[0].due == cyc) begin
      check("p0_valid", 32'(p0_valid), 32'd1);
      check("p0_err",   32'(p0_err),   32'(q0[0].err));
      check("p0_rdata", p0_rdata,      q0[0].rdata);
      void'(q0.pop_front());
    end else check("p0_valid_idle", 32'(p0_valid), 32'd0);
    if (q1.size() > 0 && q1[0].due == cyc) begin
      check("p1_valid", 32'(p1_valid), 32'd1);
      check("p1_err",   32'(p1_err),   32'(q1[0].err));
      check("p1_rdata", p1_rdata,      q1[0].rdata);
      void'(q1.pop_front());
    end else check("p1_valid_idle", 32'(p1_valid), 32'd0);
  end

  task automatic drive_idle();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  function automatic exp_t expect_resp(req_t r);
    exp_t e;
    e.due   = cyc + 1;
    e.err   = (r.a >= DEPTH);
    e.rdata = (!r.we && r.a < DEPTH) ? ref_mem[int'(r.a)] : 32'd0;
    return e;
  endfunction

  // One clock cycle: drive pending requests, predict grants/memory drive, update model.
  task automatic step();
    bit   g0, g1, nf;
    req_t s;
    p0_req = pd0.v; p0_we = pd0.we; p0_addr = pd0.a; p0_wdata = pd0.d;
    p1_req = pd1.v; p1_we = pd1.we; p1_addr = pd1.a; p1_wdata = pd1.d;
    @(negedge clk);
    if (forced) begin g0 = 0;      g1 = pd1.v;          end
    else        begin g0 = pd0.v;  g1 = pd1.v & ~pd0.v; end
    check("p0_gnt", 32'(p0_gnt), 32'(g0));
    check("p1_gnt", 32'(p1_gnt), 32'(g1));
    s = '{v: 0, we: 0, a: 32'd0, d: 32'd0};
    if (g0) s = pd0; else if (g1) s = pd1;
    check("mem_a",  mem_a,  s.a);
    check("mem_wd", mem_wd, s.d);
    check("mem_we", 32'(mem_we), 32'(s.v && s.we && s.a < DEPTH));
    if (g0) q0.push_back(expect_resp(pd0));
    if (g1) q1.push_back(expect_resp(pd1));
    @(posedge clk);
    if (s.v && s.we && s.a < DEPTH) ref_mem[int'(s.a)] = s.d;
    nf = !forced && lost == SM;
    if (g1 || !pd1.v) lost = 0;
    else if (lost < SM) lost++;
    forced = nf;
    if (g0) pd0.v = 0;
    if (g1) pd1.v = 0;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((pd0.v || pd1.v) && n < 20) begin step(); n++; end
    if (pd0.v || pd1.v) begin
      fails++; tests++;
      $display("FAIL drain_timeout actual=pending required=granted");
      pd0.v = 0; pd1.v = 0;
    end
    step(); step();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_p0_valid"}, 32'(p0_valid), 32'd0);
    check({tag, "_p1_valid"}, 32'(p1_valid), 32'd0);
    check({tag, "_p0_err"},   32'(p0_err),   32'd0);
    check({tag, "_p1_err"},   32'(p1_err),   32'd0);
    check({tag, "_p0_rdata"}, p0_rdata,      32'd0);
    check({tag, "_p1_rdata"}, p1_rdata,      32'd0);
    check({tag, "_p0_gnt"},   32'(p0_gnt),   32'd0);
    check({tag, "_p1_gnt"},   32'(p1_gnt),   32'd0);
    check({tag, "_mem_we"},   32'(mem_we),   32'd0);
    check({tag, "_mem_a"},    mem_a,         32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    pd0 = '{v: 0, we: 0, a: 32'd0, d: 32'd0};
    pd1 = pd0;
    forced = 0; lost = 0;
    drive_idle();
    rst_n = 0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    rst_n = 1;

    // Port 0 write then read back.
    pd0 = '{v: 1, we: 1, a: 32'd5, d: 32'h1234};
    step();
    pd0 = '{v: 1, we: 0, a: 32'd5, d: 32'd0};
    step();
    drain();

    // Both ports read every cycle: starvation guard must periodically serve port 1.
    for (int i = 0; i < 16; i++) begin
      if (!pd0.v) pd0 = '{v: 1, we: 0, a: 32'($urandom_range(0, DEPTH-1)), d: 32'd0};
      if (!pd1.v) pd1 = '{v: 1, we: 0, a: 32'($urandom_range(0, DEPTH-1)), d: 32'd0};
      step();
    end
    drain();

    // Port 1 out-of-range write, then read of the last legal word.
    pd1 = '{v: 1, we: 1, a: 32'd51, d: 32'hFFFF};
    step();
    pd1 = '{v: 1, we: 0, a: 32'd50, d: 32'd0};
    step();
    drain();

    // Port 0 writes addr 7 while port 1 waits to read it.
    pd0 = '{v: 1, we: 1, a: 32'd7, d: 32'hA5A5_0707};
    pd1 = '{v: 1, we: 0, a: 32'd7, d: 32'd0};
    step();
    step();
    drain();

    // Reset while a port 0 response is being presented.
    pd0 = '{v: 1, we: 0, a: 32'd3, d: 32'd0};
    step();
    drive_idle();
    check("rst_pre_valid", 32'(p0_valid), 32'd1);
    rst_n = 0;
    q0.delete(); q1.delete();
    forced = 0; lost = 0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    check_all_zero("mid_reset_hold");
    rst_n = 1;
    step();

    // Port 1 alone reads address 0.
    pd1 = '{v: 1, we: 0, a: 32'd0, d: 32'd0};
    step();
    drain();

    // Randomized traffic with held requests, occasional out-of-range addresses.
    for (int i = 0; i < 3000; i++) begin
      if (!pd0.v && $urandom_range(0, 9) < 6)
        pd0 = '{v: 1, we: 1'($urandom_range(0, 1)), a: 32'($urandom_range(0, 57)), d: $urandom};
      if (!pd1.v && $urandom_range(0, 9) < 6)
        pd1 = '{v: 1, we: 1'($urandom_range(0, 1)), a: 32'($urandom_range(0, 57)), d: $urandom};
      step();
    end
    drain();

    // Final memory image must agree with the model.
    for (int i = 0; i < DEPTH; i++) check("mem_image", tb_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
